// File: rtl/poly_ring_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | poly_ring_mult: two-stage multiplier in Z_Q[x]/(x^N+1)                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module poly_ring_mult #(
  parameter int Q = 17,
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic signed [W-1:0] polynomial1    [N],
  input  logic signed [W-1:0] polynomial2    [N],
  output logic signed [W-1:0] polynomial_out [N]
);

  localparam int RW = 16;
  // Wide enough for a W-bit input and for N products of two (Q-1) operands.
  localparam int CW = (W > 36) ? W : 36;
  localparam logic signed [CW-1:0] QS = CW'(Q);

  function automatic logic [RW-1:0] mod_q(input logic signed [CW-1:0] x);
    logic signed [CW-1:0] r;
    r = x % QS;
    if (r < 0) r = r + QS;
    return r[RW-1:0];
  endfunction

  logic [RW-1:0] ra_q  [N];
  logic [RW-1:0] rb_q  [N];
  logic [RW-1:0] ra_d  [N];
  logic [RW-1:0] rb_d  [N];
  logic [RW-1:0] out_q [N];
  logic [RW-1:0] out_d [N];

  logic signed [CW-1:0] ea;
  logic signed [CW-1:0] eb;
  logic signed [CW-1:0] prod;
  logic signed [CW-1:0] acc;

  always_comb begin
    ea   = '0;
    eb   = '0;
    prod = '0;
    acc  = '0;
    for (int k = 0; k < N; k++) begin
      ra_d[k] = mod_q(CW'(polynomial1[k]));
      rb_d[k] = mod_q(CW'(polynomial2[k]));
    end
    // Negacyclic convolution: terms with i+j >= N wrap with a sign flip.
    for (int k = 0; k < N; k++) begin
      acc = '0;
      for (int i = 0; i < N; i++) begin
        ea   = CW'(ra_q[i]);
        eb   = CW'(rb_q[(k - i + N) % N]);
        prod = ea * eb;
        if (i <= k) acc = acc + prod;
        else        acc = acc - prod;
      end
      out_d[k] = mod_q(acc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        ra_q[k]  <= '0;
        rb_q[k]  <= '0;
        out_q[k] <= '0;
      end
    end else if (enable) begin
      for (int k = 0; k < N; k++) begin
        ra_q[k]  <= ra_d[k];
        rb_q[k]  <= rb_d[k];
        out_q[k] <= out_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      polynomial_out[k] = W'(out_q[k]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_poly_ring_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_poly_ring_mult: self-checking bench for poly_ring_mult                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_poly_ring_mult;

  typedef int poly_t [4];

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic signed [31:0] p1 [4];
  logic signed [31:0] p2 [4];
  logic signed [31:0] po [4];
  logic [127:0]       out_flat;

  int total;
  int bad;

  poly_ring_mult #(.Q(17), .N(4), .W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .polynomial1    (p1),
    .polynomial2    (p2),
    .polynomial_out (po)
  );

  assign out_flat = {po[3], po[2], po[1], po[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mq(input longint x);
    longint r;
    r = ((x % 17) + 17) % 17;
    return int'(r);
  endfunction

  // Schoolbook product, then fold with x^4 = -1.
  task automatic ref_mult(input poly_t a, input poly_t b, output poly_t c);
    longint full [7];
    for (int i = 0; i < 7; i++) full[i] = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        full[i+j] += longint'(mq(a[i])) * longint'(mq(b[j]));
    for (int k = 0; k < 3; k++) c[k] = mq(full[k] - full[k+4]);
    c[3] = mq(full[3]);
  endtask

  function automatic logic [127:0] pack(input poly_t c);
    return {c[3], c[2], c[1], c[0]};
  endfunction

  task automatic set_in(input poly_t a, input poly_t b);
    for (int i = 0; i < 4; i++) begin
      p1[i] = a[i];
      p2[i] = b[i];
    end
  endtask

  task automatic tick(input bit en);
    enable = en;
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_coef();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 60)) - 30;
  endfunction

  task automatic test_reset();
    poly_t a, b;
    a = '{5, 6, 7, 8};
    b = '{3, 1, 4, 1};
    set_in(a, b);
    rst_n = 1'b0;
    tick(1);
    tick(1);
    total++;
    if (out_flat !== 128'd0) begin
      bad++;
      $display("FAIL reset_hold: got %h want 0", out_flat);
    end
    rst_n = 1'b1;
    tick(1);
    total++;
    if (out_flat !== 128'd0) begin
      bad++;
      $display("FAIL reset_first_edge: got %h want 0", out_flat);
    end
  endtask

  task automatic test_identity();
    poly_t a, b, e;
    a = '{1, 2, 3, 4};
    b = '{1, 0, 0, 0};
    e = '{1, 2, 3, 4};
    set_in(a, b);
    tick(1);
    tick(1);
    total++;
    if (out_flat !== pack(e)) begin
      bad++;
      $display("FAIL identity: got %h want %h", out_flat, pack(e));
    end
    set_in(b, a);
    tick(1);
    tick(1);
    total++;
    if (out_flat !== pack(e)) begin
      bad++;
      $display("FAIL identity_swap: got %h want %h", out_flat, pack(e));
    end
  endtask

  task automatic test_wrap();
    poly_t a, b, e;
    a = '{0, 1, 0, 0};
    b = '{0, 0, 0, 1};
    e = '{16, 0, 0, 0};
    set_in(a, b);
    tick(1);
    tick(1);
    total++;
    if (out_flat !== pack(e)) begin
      bad++;
      $display("FAIL wrap: got %h want %h", out_flat, pack(e));
    end
  endtask

  task automatic test_all_ones();
    poly_t a, e;
    a = '{1, 1, 1, 1};
    e = '{15, 0, 2, 4};
    set_in(a, a);
    tick(1);
    tick(1);
    total++;
    if (out_flat !== pack(e)) begin
      bad++;
      $display("FAIL all_ones: got %h want %h", out_flat, pack(e));
    end
  endtask

  task automatic test_reduction();
    poly_t a, b, e;
    a = '{-1, 0, 0, 0};
    b = '{3, 0, 0, 0};
    e = '{14, 0, 0, 0};
    set_in(a, b);
    tick(1);
    tick(1);
    total++;
    if (out_flat !== pack(e)) begin
      bad++;
      $display("FAIL reduce_neg: got %h want %h", out_flat, pack(e));
    end
    a = '{20, 0, 0, 0};
    b = '{1, 0, 0, 0};
    e = '{3, 0, 0, 0};
    set_in(a, b);
    tick(1);
    tick(1);
    total++;
    if (out_flat !== pack(e)) begin
      bad++;
      $display("FAIL reduce_big: got %h want %h", out_flat, pack(e));
    end
  endtask

  task automatic test_stall();
    poly_t a, b, g1, g2, held, e;
    a    = '{2, 0, 0, 0};
    b    = '{3, 0, 0, 0};
    held = '{6, 0, 0, 0};
    e    = '{15, 0, 2, 4};
    set_in(a, b);
    tick(1);
    a = '{1, 1, 1, 1};
    set_in(a, a);
    tick(1);
    total++;
    if (out_flat !== pack(held)) begin
      bad++;
      $display("FAIL stall_pre: got %h want %h", out_flat, pack(held));
    end
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 4; i++) begin
        g1[i] = rnd_coef();
        g2[i] = rnd_coef();
      end
      set_in(g1, g2);
      tick(0);
      total++;
      if (out_flat !== pack(held)) begin
        bad++;
        $display("FAIL stall_hold%0d: got %h want %h", n, out_flat, pack(held));
      end
    end
    tick(1);
    total++;
    if (out_flat !== pack(e)) begin
      bad++;
      $display("FAIL stall_resume: got %h want %h", out_flat, pack(e));
    end
  endtask

  task automatic test_random();
    poly_t pa, pb, ca, cb, exp_c;
    bit en;
    for (int i = 0; i < 4; i++) begin
      pa[i] = rnd_coef();
      pb[i] = rnd_coef();
    end
    set_in(pa, pb);
    tick(1);
    exp_c = '{0, 0, 0, 0};
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 4; i++) begin
        ca[i] = rnd_coef();
        cb[i] = rnd_coef();
      end
      en = ($urandom_range(0, 3) != 0);
      set_in(ca, cb);
      if (n == 0) en = 1'b1;
      tick(en);
      if (en) begin
        ref_mult(pa, pb, exp_c);
        pa = ca;
        pb = cb;
      end
      total++;
      if (out_flat !== pack(exp_c)) begin
        bad++;
        $display("FAIL random%0d: got %h want %h", n, out_flat, pack(exp_c));
      end
    end
  endtask

  task automatic test_async_reset();
    poly_t a, b, e, z;
    a = '{1, 1, 1, 1};
    z = '{0, 0, 0, 0};
    set_in(a, a);
    tick(1);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_flat !== pack(z)) begin
      bad++;
      $display("FAIL async_clear: got %h want 0", out_flat);
    end
    #2;
    rst_n = 1'b1;
    a = '{1, 2, 3, 4};
    b = '{1, 0, 0, 0};
    e = '{1, 2, 3, 4};
    set_in(a, b);
    tick(1);
    total++;
    if (out_flat !== pack(z)) begin
      bad++;
      $display("FAIL async_first: got %h want 0", out_flat);
    end
    tick(1);
    total++;
    if (out_flat !== pack(e)) begin
      bad++;
      $display("FAIL async_second: got %h want %h", out_flat, pack(e));
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p1[i] = '0;
      p2[i] = '0;
    end
    #2;
    test_reset();
    test_identity();
    test_wrap();
    test_all_ones();
    test_reduction();
    test_stall();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/poly_ring_mult.md
Name: poly_ring_mult

Overview:
- Multiplies two degree-3 polynomials in the Baby-Kyber ring Z_Q[x]/(x^4+1), Q=17.
- Output coefficients are fully reduced to [0, Q-1].
- Decryption instantiates two of these to form s·u terms. Encryption reuses it for A·r and t·r.
- Two-stage, enable-gated pipeline with fixed latency. There is no handshake.

Parameters:
- Q, 17, coefficient modulus (odd prime, < 2^15).
- N, 4, number of coefficients per polynomial. The ring is x^N+1. RTL need only support N=4.
- W, 32, coefficient width in bits (signed two's complement).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  pipeline advance; when low, all registers hold.
- polynomial1  input  signed [W-1:0] x N  operand a. Index 0 is the constant term, index 3 is the x^3 coefficient.
- polynomial2  input  signed [W-1:0] x N  operand b, same ordering.
- polynomial_out  output  signed [W-1:0] x N  product c = a·b mod (x^4+1, Q). Registered; each element is in [0, Q-1].

Behaviour:
- Interface is fixed: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time, independent of clk) clears:
  - stage-1 operand registers to 0;
  - polynomial_out to 0 for all four coefficients.
  - After release, outputs stay 0 until enable-qualified edges propagate new data.
- Canonical reduction mod(x) for signed x: r = x rem Q (truncating); if r<0 then r += Q. Result is always in [0, Q-1].
- Stage 1, rising edge with enable=1:
  - ra[i] <= mod(polynomial1[i]);
  - rb[i] <= mod(polynomial2[i]);
  - for i = 0..3. Negative and out-of-range inputs are legal and are reduced here.
- Stage 2, same edge with enable=1, using the current ra/rb register contents, negacyclic convolution:
  - c[k] = sum over i+j=k of ra[i]·rb[j], minus sum over i+j=k+4 of ra[i]·rb[j];
  - polynomial_out[k] <= mod(c[k]).
  - Expanded terms:
    - c0 = a0b0 − a1b3 − a2b2 − a3b1
    - c1 = a0b1 + a1b0 − a2b3 − a3b2
    - c2 = a0b2 + a1b1 + a2b0 − a3b3
    - c3 = a0b3 + a1b2 + a2b1 + a3b0
- Intermediate width: operands ≤16, so |c[k]| ≤ 1024. Use at least 12-bit signed internally; sign-extend the result to W.
- Latency: inputs applied before edge n (enable=1) appear on polynomial_out after edge n+1 (enable=1). That is 2 enable-qualified edges.
- Throughput: one new operand pair per enabled cycle. Inputs may change every cycle.
- enable=0: both stages hold; polynomial_out is stable. Stalling mid-pipeline keeps the in-flight operand pair in stage 1 for the next enabled edge.
- Reset asserted mid-operation: all in-flight data is discarded. The next output after release comes from operands sampled after release.
- Multiplication must be commutative: swapping polynomial1/polynomial2 gives an identical result.
- No X propagation: every register has a defined reset value.

Test Plan:
- Identity: a=[1,2,3,4], b=[1,0,0,0], enable=1 held → after 2 edges, out=[1,2,3,4]. Swapping a/b gives the same result.
- Negacyclic wrap: a=[0,1,0,0] (x), b=[0,0,0,1] (x^3) → out=[16,0,0,0] (x^4 = −1 ≡ 16).
- All-ones: a=b=[1,1,1,1] → out=[15,0,2,4].
- Input reduction: a=[−1,0,0,0], b=[3,0,0,0] → out=[14,0,0,0]. Also a=[20,0,0,0], b=[1,0,0,0] → out=[3,0,0,0].
- Enable/stall:
  - apply a=[1,1,1,1], b=[1,1,1,1]; one enabled edge; then enable=0 for 3 edges while inputs change to garbage;
  - out must hold its prior value;
  - then enable=1 for one edge → out=[15,0,2,4].
- Async reset: after valid output, pulse rst_n low between clock edges → out=[0,0,0,0] immediately. After release with enable=1, first new result appears on the 2nd enabled edge.
